// File: rtl/wave_sweep_ctrl.sv
// Frequency sweep sequencer: steps a LUT multiplier word from f_start toward f_stop,
// holding each value for a programmable dwell, in single, sawtooth or triangle mode.
module wave_sweep_ctrl #(
    parameter int FREQ_W  = 4,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [1:0]         mode,
    output logic [FREQ_W-1:0]  freq_mul,
    output logic               step_stb,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [FREQ_W-1:0]  fs_q, fe_q, freq_q;
    logic [DWELL_W-1:0] dw_q, cnt_q;
    logic [1:0]         mode_q;
    logic               up_q, stb_q, busy_q, done_q;

    logic [DWELL_W-1:0] dwell_eff;
    logic [FREQ_W-1:0]  hi, lo, step_d, back_d;
    logic               single, tri_mode, turn_d;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign single    = (mode_q == 2'd0) || (mode_q == 2'd3);
    assign tri_mode  = (mode_q == 2'd2);
    assign hi        = (fe_q >= fs_q) ? fe_q : fs_q;
    assign lo        = (fe_q >= fs_q) ? fs_q : fe_q;
    assign step_d    = up_q ? freq_q + 1'b1 : freq_q - 1'b1;
    assign back_d    = up_q ? freq_q - 1'b1 : freq_q + 1'b1;
    // Triangle turns around on the endpoint lying in the current direction of travel.
    assign turn_d    = up_q ? (freq_q == hi) : (freq_q == lo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            freq_q  <= '0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            up_q    <= 1'b1;
            fs_q    <= '0;
            fe_q    <= '0;
            dw_q    <= '0;
            mode_q  <= '0;
        end else if (abort) begin
            state_q <= IDLE;
            freq_q  <= '0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            stb_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        fs_q    <= f_start;
                        fe_q    <= f_stop;
                        dw_q    <= dwell_eff;
                        mode_q  <= mode;
                        up_q    <= (f_stop >= f_start);
                        freq_q  <= f_start;
                        cnt_q   <= dwell_eff - 1'b1;
                        stb_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        cnt_q <= dw_q - 1'b1;
                        stb_q <= 1'b1;
                        if (tri_mode) begin
                            // A zero-span triangle just re-schedules the same value.
                            if (fs_q == fe_q) begin
                                freq_q <= fs_q;
                            end else if (turn_d) begin
                                freq_q <= back_d;
                                up_q   <= ~up_q;
                            end else begin
                                freq_q <= step_d;
                            end
                        end else if (freq_q == fe_q) begin
                            if (single) begin
                                stb_q   <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                freq_q <= fs_q;
                            end
                        end else begin
                            freq_q <= step_d;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign freq_mul = freq_q;
    assign step_stb = stb_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_wave_sweep_ctrl.sv
// Bench for wave_sweep_ctrl: directed and random sweeps checked cycle by cycle
// against a closed-form model of the expected output sequence.
module tb_wave_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [3:0]  f_start, f_stop;
    logic [15:0] dwell;
    logic [1:0]  mode;
    logic [3:0]  freq_mul;
    logic        step_stb, busy, done;

    int cmp = 0;
    int err = 0;

    wave_sweep_ctrl #(.FREQ_W(4), .DWELL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .f_start(f_start), .f_stop(f_stop), .dwell(dwell), .mode(mode),
        .freq_mul(freq_mul), .step_stb(step_stb), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".freq"}, 32'(freq_mul), 0);
        chk({tag, ".stb"},  32'(step_stb), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
    endtask

    // Expected outputs k cycles after the start edge (k=0 is the first busy cycle).
    task automatic model(input int fs, input int fe, input int D, input int md, input int k,
                         output int ef, output int es, output int eb, output int ed);
        int n, dir, i, p, pos;
        n   = ((fe >= fs) ? fe - fs : fs - fe) + 1;
        dir = (fe >= fs) ? 1 : -1;
        if (md == 0 || md == 3) begin
            if (k < n * D) begin
                ef = fs + dir * (k / D);
                es = (k % D == 0) ? 1 : 0;
                eb = 1;
                ed = 0;
            end else begin
                ef = fe;
                es = 0;
                eb = 0;
                ed = (k == n * D) ? 1 : 0;
            end
        end else begin
            i = k / D;
            if (md == 1) pos = i % n;
            else if (n == 1) pos = 0;
            else begin
                p   = 2 * n - 2;
                pos = i % p;
                if (pos >= n) pos = p - pos;
            end
            ef = fs + dir * pos;
            es = (k % D == 0) ? 1 : 0;
            eb = 1;
            ed = 0;
        end
    endtask

    // Launch a sweep and check ncyc consecutive cycles; noise scrambles inputs and
    // pulses start while the sweep is running, which must have no effect.
    task automatic sweep(input int fs, input int fe, input int dw, input int md,
                         input int ncyc, input bit noise, input bit no_gap);
        int d, n, ef, es, eb, ed;
        bit single;
        string tag;
        d      = (dw == 0) ? 1 : dw;
        n      = ((fe >= fs) ? fe - fs : fs - fe) + 1;
        single = (md == 0 || md == 3);
        if (!no_gap) @(negedge clk);
        f_start = 4'(fs); f_stop = 4'(fe); dwell = 16'(dw); mode = 2'(md); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clk);
            model(fs, fe, d, md, k, ef, es, eb, ed);
            tag = $sformatf("sw(%0d,%0d,%0d,m%0d)k%0d", fs, fe, dw, md, k);
            chk({tag, ".freq"}, 32'(freq_mul), ef);
            chk({tag, ".stb"},  32'(step_stb), es);
            chk({tag, ".busy"}, 32'(busy), eb);
            chk({tag, ".done"}, 32'(done), ed);
            if (noise) begin
                f_start = 4'($urandom); f_stop = 4'($urandom);
                dwell = 16'($urandom_range(0, 7)); mode = 2'($urandom);
                start = (single && k >= n * d) ? 1'b0 : 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
    endtask

    task automatic do_abort(input string tag);
        @(negedge clk);
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_zero(tag);
    endtask

    initial begin
        int fs, fe, dw, md, n, d, nc;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        f_start = '0; f_stop = '0; dwell = '0; mode = '0;
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle_after_reset");

        // Single 2->4 dwell 3, then back-to-back start the cycle after done.
        sweep(2, 4, 3, 0, 11, 1'b1, 1'b0);
        sweep(5, 5, 0, 3, 4, 1'b0, 1'b1);
        // Triangle 1..3 dwell 1 and sawtooth 15->13 dwell 2.
        sweep(1, 3, 1, 2, 14, 1'b1, 1'b0);
        do_abort("abort_tri");
        sweep(15, 13, 2, 1, 16, 1'b1, 1'b0);
        do_abort("abort_rep");
        // Zero-span holds in repeat and triangle.
        sweep(9, 9, 2, 1, 8, 1'b0, 1'b0);
        do_abort("abort_hold_rep");
        sweep(6, 6, 3, 2, 9, 1'b0, 1'b0);
        do_abort("abort_hold_tri");

        // Abort together with start: sweep must not begin.
        @(negedge clk);
        f_start = 4'd7; f_stop = 4'd9; dwell = 16'd1; mode = 2'd0;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_zero($sformatf("abort_with_start_k%0d", k));
            @(negedge clk);
        end

        // Abort mid-sweep: no done afterwards, freq stays 0.
        sweep(2, 9, 2, 0, 5, 1'b1, 1'b0);
        do_abort("abort_mid");
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk_zero($sformatf("after_abort_k%0d", k));
        end

        // Asynchronous reset mid-sweep.
        sweep(3, 12, 3, 2, 7, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk);
        chk_zero("rst_held");
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_zero($sformatf("after_rst_k%0d", k));
        end
        sweep(12, 10, 1, 0, 5, 1'b0, 1'b0);

        // Random sweeps in every mode.
        for (int r = 0; r < 20; r++) begin
            fs = $urandom_range(0, 15);
            fe = ($urandom_range(0, 3) == 0) ? fs : $urandom_range(0, 15);
            dw = $urandom_range(0, 4);
            md = $urandom_range(0, 3);
            d  = (dw == 0) ? 1 : dw;
            n  = ((fe >= fs) ? fe - fs : fs - fe) + 1;
            if (md == 0 || md == 3) nc = n * d + 3;
            else nc = (3 * n * d > 48) ? 48 : 3 * n * d + 2;
            sweep(fs, fe, dw, md, nc, 1'b1, 1'b0);
            if (!(md == 0 || md == 3)) do_abort($sformatf("abort_rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
